// File: rtl/pattern_src_pkg.sv
// Shared types and default sizing for the pattern stream source.
// Used by pattern_src_buffer and pattern_stream_source.
package pattern_src_pkg;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_DEPTH          = 32;
    localparam int DEF_ACK_LOW_CYCLES = 2;
    localparam int DEF_CNT_W          = 8;

    // Index addresses one entry; length must also be able to hold DEPTH itself.
    localparam int DEF_IDX_W = $clog2(DEF_DEPTH);
    localparam int DEF_LEN_W = DEF_IDX_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        ACK_LOW,
        RESUME,
        DONE
    } state_t;

endpackage

// File: rtl/pattern_src_buffer.sv
// Byte buffer for the stream source: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module pattern_src_buffer
    import pattern_src_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pattern_stream_source.sv
// Byte-stream source for the pattern detector: streams a loaded buffer, pauses
// with ack low on each match, counts matches. STREAM_LOOP_EN enables wrap-around.
module pattern_stream_source
    import pattern_src_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int ACK_LOW_CYCLES = DEF_ACK_LOW_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset_sync,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       found_pattern,
    output logic [DATA_W-1:0]          data,
    output logic                       ack,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           match_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int LOW_W = (ACK_LOW_CYCLES > 1) ? $clog2(ACK_LOW_CYCLES) : 1;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LOW_W-1:0]  low_cnt_reg;

    logic              last;
    logic [IDX_W-1:0]  raddr;
    logic [DATA_W-1:0] rdata;

    assign last = (({1'b0, idx_reg} + LEN_W'(1)) == len_reg);

    // Read buf[0] when launching (or wrapping), otherwise look one byte ahead.
    assign raddr = (state_reg == STREAM && !last) ? idx_reg + IDX_W'(1) : '0;

    pattern_src_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_buffer (
        .clk   (clk),
        .we    (wr_en && !busy),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset_sync) begin
        if (!reset_sync) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            len_reg     <= '0;
            low_cnt_reg <= '0;
            data        <= '0;
            ack         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        match_count <= '0;
                        if (len != '0) begin
                            state_reg <= STREAM;
                            idx_reg   <= '0;
                            len_reg   <= len;
                            data      <= rdata;
                            ack       <= 1'b1;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end else begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state_reg <= DONE;
                        ack       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (found_pattern) begin
                        // The current byte is re-presented after the pause.
                        state_reg   <= ACK_LOW;
                        ack         <= 1'b0;
                        low_cnt_reg <= LOW_W'(ACK_LOW_CYCLES - 1);
                        if (match_count != '1) begin
                            match_count <= match_count + CNT_W'(1);
                        end
                    end else if (!last) begin
                        idx_reg <= idx_reg + IDX_W'(1);
                        data    <= rdata;
                    end else begin
`ifdef STREAM_LOOP_EN
                        idx_reg <= '0;
                        data    <= rdata;
`else
                        state_reg <= DONE;
                        ack       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
`endif
                    end
                end
                ACK_LOW: begin
                    if (abort) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (low_cnt_reg == '0) begin
                        state_reg <= RESUME;
                        ack       <= 1'b1;
                    end else begin
                        low_cnt_reg <= low_cnt_reg - LOW_W'(1);
                    end
                end
                RESUME: begin
                    if (abort) begin
                        state_reg <= DONE;
                        ack       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state_reg <= STREAM;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_stream_source.sv
// Self-checking bench for pattern_stream_source: expected per-cycle traces are
// expanded from the byte list and a randomized match/abort schedule.
module tb_pattern_stream_source;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int ACKN   = 2;
    localparam int CNT_W  = 8;
    localparam int IDX_W  = 5;
    localparam int LEN_W  = 6;
`ifdef STREAM_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_sync = 1'b1;
    logic              wr_en = 1'b0;
    logic [IDX_W-1:0]  wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              found_pattern = 1'b0;
    logic [DATA_W-1:0] data;
    logic              ack;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  match_count;

    pattern_stream_source #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .ACK_LOW_CYCLES (ACKN),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_sync    (reset_sync),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .len           (len),
        .start         (start),
        .abort         (abort),
        .found_pattern (found_pattern),
        .data          (data),
        .ack           (ack),
        .busy          (busy),
        .done          (done),
        .match_count   (match_count)
    );

    always #5 clk = ~clk;

    // One expected cycle of the stream: outputs plus the stimulus for that cycle.
    typedef struct {
        logic [7:0] d;
        logic       a;
        logic       f;
        logic       ab;
        int         mc;
    } ent_t;

    ent_t       q[$];
    logic [7:0] model_buf [DEPTH];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Expand the byte sequence into cycles: each match shows the byte once with
    // ack high, then ACKN cycles ack low, one resume cycle, then re-presents it.
    task automatic build(input int ln, input int pct, input int force_n, input int abort_at);
        int         pres;
        int         m;
        int         fl;
        int         ab_at;
        bit         hit;
        logic [7:0] b;
        ent_t       e;
        q.delete();
        m = 0;
        fl = force_n;
        ab_at = abort_at;
        pres = LOOP ? ln * 3 : ln;
        for (int p = 0; p < pres; p++) begin
            b = model_buf[p % ln];
            while (1) begin
                hit = (fl > 0) || (pct > 0 && int'($urandom_range(99)) < pct);
                e.d = b; e.a = 1'b1; e.f = hit; e.ab = 1'b0; e.mc = m;
                q.push_back(e);
                if (!hit) break;
                m++;
                if (fl > 0) fl--;
                for (int i = 0; i < ACKN; i++) begin
                    e.d = b; e.a = 1'b0; e.f = 1'($urandom_range(1)); e.ab = 1'b0; e.mc = m;
                    q.push_back(e);
                end
                // found_pattern held high during resume must be ignored
                e.d = b; e.a = 1'b1; e.f = 1'b1; e.ab = 1'b0; e.mc = m;
                q.push_back(e);
            end
        end
        if (LOOP && (ab_at < 0 || ab_at >= q.size())) ab_at = q.size() - 1;
        if (ab_at >= 0 && ab_at < q.size()) begin
            q[ab_at].ab = 1'b1;
            while (q.size() > ab_at + 1) void'(q.pop_back());
        end
    endtask

    task automatic run(input int ln, input int pct, input int force_n, input int abort_at, input bit sim_wr);
        logic [7:0] nv;
        int         last;
        build(ln, pct, force_n, abort_at);
        nv = 8'($urandom);
        @(negedge clk);
        len = LEN_W'(ln);
        start = 1'b1;
        if (sim_wr) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = nv;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        if (sim_wr) model_buf[0] = nv;
        for (int k = 0; k < q.size(); k++) begin
            chk("data", 32'(data), 32'(q[k].d));
            chk("ack", 32'(ack), 32'(q[k].a));
            chk("busy", 32'(busy), 32'd1);
            chk("done", 32'(done), 32'd0);
            chk("match_count", 32'(match_count), sat(q[k].mc));
            found_pattern = q[k].f;
            abort = q[k].ab;
            // writes while busy must be dropped
            wr_en = 1'($urandom_range(1));
            wr_addr = IDX_W'($urandom);
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        found_pattern = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
        last = q.size() - 1;
        chk("end_done", 32'(done), 32'd1);
        chk("end_ack", 32'(ack), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_data", 32'(data), 32'(q[last].d));
        chk("end_match_count", 32'(match_count), sat(q[last].mc));
        $display("run len=%0d cycles=%0d aborted=%0d matches=%0d", ln, q.size(), q[last].ab, q[last].mc);
    endtask

    task automatic write(input int addr, input logic [7:0] v);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = IDX_W'(addr); wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
        model_buf[addr] = v;
    endtask

    initial begin
        #2 reset_sync = 1'b0;
        #1;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_match_count", 32'(match_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_sync = 1'b1;

        // Plain pass over 0x10..0x1F, then a run with random matches
        for (int i = 0; i < DEPTH; i++) write(i, (i < 16) ? 8'(8'h10 + i) : 8'($urandom));
        run(16, 0, 0, -1, 1'b0);
        run(16, 20, 0, -1, 1'b0);

        // Saturation: 256 matches on the first byte
        run(16, 0, 256, -1, 1'b0);

        // len=0 completes at once with no streaming
        @(negedge clk);
        len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_ack", 32'(ack), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_match_count", 32'(match_count), 32'd0);
        $display("run len=0 done=%0d", done);

        write(0, 8'hA5);
        run(1, 0, 0, -1, 1'b0);

        // Asynchronous reset in the middle of a stream
        @(negedge clk);
        len = LEN_W'(16); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            chk("pre_rst_data", 32'(data), 32'(model_buf[k]));
            if (k < 5) @(negedge clk);
        end
        #2 reset_sync = 1'b0;
        #1;
        chk("async_rst_data", 32'(data), 32'd0);
        chk("async_rst_ack", 32'(ack), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_match_count", 32'(match_count), 32'd0);
        $display("async reset mid-stream applied");
        @(negedge clk);
        reset_sync = 1'b1;
        run(16, 10, 0, -1, 1'b0);

        // Four-byte buffer: loops until abort when enabled, single pass otherwise
        write(0, 8'hA1); write(1, 8'hB2); write(2, 8'hC3); write(3, 8'hD4);
        run(4, 25, 0, -1, 1'b0);
        run(4, 0, 0, 10, 1'b0);

        // Full-depth runs with random aborts, then start racing a write to buf[0]
        for (int r = 0; r < 3; r++) begin
            run(DEPTH, 10, 0, int'($urandom_range(60)), 1'b0);
        end
        run(8, 0, 0, -1, 1'b1);
        run(8, 15, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
